// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: diff = op_a - op_b - borrow_in, one bit per clock, LSB first.
// Optional signed-overflow output is enabled by defining SUB_OVERFLOW_EN.
module serial_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             borrow_in,
  output logic             result_valid,
  input  logic             result_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             zero,
`ifdef SUB_OVERFLOW_EN
  output logic             overflow,
`endif
  output logic [1:0]       state_dbg
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; valid never depends combinationally on ready, and a producer
  // holds valid plus its data stable until that transfer edge.

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] d_sr;
  logic [CW-1:0]    cnt;
  logic             br;

  logic             a_bit;
  logic             b_bit;
  logic             d_bit;
  logic             br_next;
  logic [WIDTH-1:0] d_final;

  assign state_dbg = state;

  // Full-subtractor cell operating on the current LSBs.
  always_comb begin
    a_bit   = a_sr[0];
    b_bit   = b_sr[0];
    d_bit   = a_bit ^ b_bit ^ br;
    br_next = (~a_bit & b_bit) | (~a_bit & br) | (b_bit & br);
    d_final = {d_bit, d_sr[WIDTH-1:1]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      start_ready  <= 1'b1;
      result_valid <= 1'b0;
      diff         <= '0;
      borrow_out   <= 1'b0;
      zero         <= 1'b0;
`ifdef SUB_OVERFLOW_EN
      overflow     <= 1'b0;
`endif
      a_sr         <= '0;
      b_sr         <= '0;
      d_sr         <= '0;
      cnt          <= '0;
      br           <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_valid && start_ready) begin
            a_sr        <= op_a;
            b_sr        <= op_b;
            br          <= borrow_in;
            cnt         <= '0;
            start_ready <= 1'b0;
            state       <= RUN;
          end
        end
        RUN: begin
          a_sr <= a_sr >> 1;
          b_sr <= b_sr >> 1;
          d_sr <= d_final;
          br   <= br_next;
          cnt  <= cnt + CW'(1);
          if (cnt == CW'(WIDTH - 1)) begin
            diff         <= d_final;
            borrow_out   <= br_next;
            zero         <= (d_final == '0);
`ifdef SUB_OVERFLOW_EN
            overflow     <= (a_bit ^ b_bit) & (a_bit ^ d_bit);
`endif
            result_valid <= 1'b1;
            state        <= DONE;
          end
        end
        DONE: begin
          // Result registers are only rewritten at the end of the next RUN.
          if (result_valid && result_ready) begin
            result_valid <= 1'b0;
            start_ready  <= 1'b1;
            state        <= IDLE;
          end
        end
        default: begin
          state        <= IDLE;
          start_ready  <= 1'b1;
          result_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
